// File: rtl/aes_key_sched_ctrl_if.sv
// rtl/aes_key_sched_ctrl_if.sv - key-load and round-key read bus for the AES-128 key-schedule controller
interface aes_key_sched_ctrl_if;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic         key_ready;
    logic         rd_en;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
    logic         rd_valid;
    logic         rd_err;

    modport master (
        output key_in, key_load, rd_en, rd_round,
        input  busy, key_ready, rd_key, rd_valid, rd_err
    );

    modport slave (
        input  key_in, key_load, rd_en, rd_round,
        output busy, key_ready, rd_key, rd_valid, rd_err
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - iterative AES-128 key schedule, one round key per clock, 11-entry bank with registered reads
module aes_key_sched_ctrl (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_key_sched_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    // Forward AES S-box, entry 0 is the leftmost byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t       r_state;
    logic [3:0]   r_rnd;
    logic [127:0] r_bank [0:10];
    logic         r_busy;
    logic         r_key_ready;
    logic [127:0] r_rd_key;
    logic         r_rd_valid;
    logic         r_rd_err;

    logic [3:0]   w_prev_idx;
    logic [127:0] w_prev;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [7:0]   w_rcon;
    logic [31:0]  w_t;
    logic [31:0]  w_n0;
    logic [31:0]  w_n1;
    logic [31:0]  w_n2;
    logic [31:0]  w_n3;
    logic [127:0] w_next;
    logic         w_rd_ok;
    logic [127:0] w_rd_data;

    // Previous round key feeding the single shared round step.
    always_comb begin
        w_prev_idx = r_rnd - 4'd1;
        w_prev     = '0;
        if (r_rnd >= 4'd1 && r_rnd <= 4'd10) begin
            w_prev = r_bank[w_prev_idx];
        end
    end

    // Round constant for the round currently being produced.
    always_comb begin
        w_rcon = 8'h00;
        case (r_rnd)
            4'd1:    w_rcon = 8'h01;
            4'd2:    w_rcon = 8'h02;
            4'd3:    w_rcon = 8'h04;
            4'd4:    w_rcon = 8'h08;
            4'd5:    w_rcon = 8'h10;
            4'd6:    w_rcon = 8'h20;
            4'd7:    w_rcon = 8'h40;
            4'd8:    w_rcon = 8'h80;
            4'd9:    w_rcon = 8'h1b;
            4'd10:   w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    // One round step: RotWord, four S-box lookups, rcon, then the xor chain.
    always_comb begin
        w_rot  = {w_prev[23:0], w_prev[31:24]};
        w_sub  = {SBOX[w_rot[31:24]], SBOX[w_rot[23:16]],
                  SBOX[w_rot[15:8]],  SBOX[w_rot[7:0]]};
        w_t    = w_sub ^ {w_rcon, 24'h000000};
        w_n0   = w_prev[127:96] ^ w_t;
        w_n1   = w_prev[95:64]  ^ w_n0;
        w_n2   = w_prev[63:32]  ^ w_n1;
        w_n3   = w_prev[31:0]   ^ w_n2;
        w_next = {w_n0, w_n1, w_n2, w_n3};
    end

    // Read lookup; only a fully expanded bank with an in-range index is served.
    always_comb begin
        w_rd_ok   = (r_state == READY) && (bus.rd_round <= 4'd10);
        w_rd_data = '0;
        if (bus.rd_round <= 4'd10) begin
            w_rd_data = r_bank[bus.rd_round];
        end
    end

    // Controller FSM with bank writes and registered read responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rnd       <= 4'd0;
            r_busy      <= 1'b0;
            r_key_ready <= 1'b0;
            r_rd_key    <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_err    <= 1'b0;
            for (int i = 0; i <= 10; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            // Reads see the state before any load taking effect this edge.
            if (bus.rd_en) begin
                r_rd_valid <= 1'b1;
                if (w_rd_ok) begin
                    r_rd_key <= w_rd_data;
                    r_rd_err <= 1'b0;
                end else begin
                    r_rd_key <= '0;
                    r_rd_err <= 1'b1;
                end
            end else begin
                r_rd_valid <= 1'b0;
                r_rd_err   <= 1'b0;
            end

            case (r_state)
                IDLE, READY: begin
                    if (bus.key_load) begin
                        r_bank[0]   <= bus.key_in;
                        r_rnd       <= 4'd1;
                        r_state     <= EXPAND;
                        r_busy      <= 1'b1;
                        r_key_ready <= 1'b0;
                    end
                end
                EXPAND: begin
                    if (bus.key_load) begin
                        // Restart: the partial schedule is simply overwritten.
                        r_bank[0]   <= bus.key_in;
                        r_rnd       <= 4'd1;
                        r_busy      <= 1'b1;
                        r_key_ready <= 1'b0;
                    end else begin
                        r_bank[r_rnd] <= w_next;
                        if (r_rnd == 4'd10) begin
                            r_state     <= READY;
                            r_busy      <= 1'b0;
                            r_key_ready <= 1'b1;
                        end else begin
                            r_rnd <= r_rnd + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_key_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.key_ready = r_key_ready;
    assign bus.rd_key    = r_rd_key;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_err    = r_rd_err;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - self-checking bench for aes_key_sched_ctrl against a word-level key expansion model
module tb_aes_key_sched_ctrl;
    logic clk;
    logic rst_n;
    aes_key_sched_ctrl_if bus();

    aes_key_sched_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_ASC  = 128'h534f4d452031323820424954204b4559;
    localparam logic [127:0] K_ZERO = 128'h0;

    int           n_checks;
    int           n_fail;
    logic [7:0]   m_sbox [0:255];
    logic [127:0] m_keys [0:10];
    bit           m_ready;
    logic [127:0] m_last_key;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from first principles: multiplicative inverse (a^254) then the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Standard 44-word FIPS-197 expansion, grouped into 11 round keys.
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {m_sbox[tmp[31:24]], m_sbox[tmp[23:16]], m_sbox[tmp[15:8]], m_sbox[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int start);
        int cnt;
        cnt = start;
        while (!bus.key_ready && cnt < 30) begin
            step();
            cnt++;
            chk("busy_ready_excl", {127'b0, bus.busy & bus.key_ready}, 128'd0);
        end
        chk("ready_latency", 128'(cnt), 128'd10);
        chk("busy_after_ready", {127'b0, bus.busy}, 128'd0);
        m_ready = 1'b1;
    endtask

    task automatic start_load(input logic [127:0] k);
        bus.key_in   = k;
        bus.key_load = 1'b1;
        step();
        bus.key_load = 1'b0;
        m_ready      = 1'b0;
        model_expand(k);
        chk("busy_rise", {127'b0, bus.busy}, 128'd1);
        chk("ready_low_on_load", {127'b0, bus.key_ready}, 128'd0);
    endtask

    task automatic load_and_wait(input logic [127:0] k, input bit read_during);
        int cnt;
        start_load(k);
        cnt = 0;
        if (read_during) begin
            bus.rd_en    = 1'b1;
            bus.rd_round = 4'($urandom_range(0, 10));
            step();
            cnt++;
            bus.rd_en = 1'b0;
            chk("exp_rd_valid", {127'b0, bus.rd_valid}, 128'd1);
            chk("exp_rd_err", {127'b0, bus.rd_err}, 128'd1);
            chk("exp_rd_key", bus.rd_key, 128'd0);
        end
        wait_ready(cnt);
    endtask

    task automatic expect_read(input int r, input string tag);
        bit ok;
        ok = m_ready && (r <= 10);
        chk({tag, "_valid"}, {127'b0, bus.rd_valid}, 128'd1);
        chk({tag, "_err"}, {127'b0, bus.rd_err}, ok ? 128'd0 : 128'd1);
        m_last_key = ok ? m_keys[r] : 128'd0;
        chk({tag, "_key"}, bus.rd_key, m_last_key);
    endtask

    task automatic read1(input int r, input string tag);
        bus.rd_en    = 1'b1;
        bus.rd_round = 4'(r);
        step();
        bus.rd_en = 1'b0;
        expect_read(r, tag);
    endtask

    task automatic read_const(input int r, input logic [127:0] exp, input string tag);
        read1(r, tag);
        chk({tag, "_vec"}, bus.rd_key, exp);
    endtask

    // Back-to-back reads every cycle, then an idle cycle checking rd_key holds.
    task automatic rd_burst(input int n);
        int r;
        bus.rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 15));
            bus.rd_round = 4'(r);
            step();
            expect_read(r, "burst");
        end
        bus.rd_en = 1'b0;
        step();
        chk("idle_valid", {127'b0, bus.rd_valid}, 128'd0);
        chk("idle_err", {127'b0, bus.rd_err}, 128'd0);
        chk("idle_hold", bus.rd_key, m_last_key);
    endtask

    initial begin
        logic [127:0] old10;
        logic [127:0] rk;
        n_checks     = 0;
        n_fail       = 0;
        m_ready      = 1'b0;
        m_last_key   = '0;
        rst_n        = 1'b0;
        bus.key_in   = '0;
        bus.key_load = 1'b0;
        bus.rd_en    = 1'b0;
        bus.rd_round = '0;
        build_sbox();
        step();
        step();
        chk("rst_busy", {127'b0, bus.busy}, 128'd0);
        chk("rst_ready", {127'b0, bus.key_ready}, 128'd0);
        chk("rst_valid", {127'b0, bus.rd_valid}, 128'd0);
        chk("rst_err", {127'b0, bus.rd_err}, 128'd0);
        chk("rst_key", bus.rd_key, 128'd0);
        rst_n = 1'b1;
        step();

        read1(0, "idle_read");

        load_and_wait(K_FIPS, 1'b1);
        read_const(1, 128'ha0fafe1788542cb123a339392a6c7605, "fips_r1");
        read_const(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_r10");
        read_const(0, K_FIPS, "fips_r0");
        read1(11, "oob11");
        read1(15, "oob15");
        rd_burst(20);

        load_and_wait(K_ASC, 1'b0);
        read_const(1, 128'he12186f2c110b4cae152fd9ec119b8c7, "asc_r1");
        read_const(10, 128'h3ea222a7987a5f4a38dc254fec19fc49, "asc_r10");

        load_and_wait(K_ZERO, 1'b1);
        read_const(1, 128'h62636363626363636263636362636363, "zero_r1");
        read_const(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "zero_r10");

        for (int k = 0; k < 3; k++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            load_and_wait(rk, 1'(k & 1));
            rd_burst(16);
        end

        // Restart four cycles into an expansion.
        start_load(K_ZERO);
        step();
        step();
        step();
        load_and_wait(K_FIPS, 1'b0);
        read_const(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "restart_r10");

        // Same-cycle read and load in READY: old key returned, load proceeds.
        old10        = m_keys[10];
        bus.key_in   = K_ZERO;
        bus.key_load = 1'b1;
        bus.rd_en    = 1'b1;
        bus.rd_round = 4'd10;
        step();
        bus.key_load = 1'b0;
        bus.rd_en    = 1'b0;
        m_ready      = 1'b0;
        model_expand(K_ZERO);
        chk("same_valid", {127'b0, bus.rd_valid}, 128'd1);
        chk("same_err", {127'b0, bus.rd_err}, 128'd0);
        chk("same_key", bus.rd_key, old10);
        chk("same_busy", {127'b0, bus.busy}, 128'd1);
        wait_ready(0);
        read_const(1, 128'h62636363626363636263636362636363, "same_new_r1");

        // Asynchronous reset in the middle of an expansion.
        start_load(K_ASC);
        step();
        step();
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {127'b0, bus.busy}, 128'd0);
        chk("arst_ready", {127'b0, bus.key_ready}, 128'd0);
        chk("arst_valid", {127'b0, bus.rd_valid}, 128'd0);
        chk("arst_err", {127'b0, bus.rd_err}, 128'd0);
        chk("arst_key", bus.rd_key, 128'd0);
        m_ready = 1'b0;
        step();
        chk("arst_hold_ready", {127'b0, bus.key_ready}, 128'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", {127'b0, bus.key_ready}, 128'd0);
        read1(3, "post_rst_read");
        load_and_wait(K_ASC, 1'b0);
        read_const(10, 128'h3ea222a7987a5f4a38dc254fec19fc49, "post_rst_r10");
        rd_burst(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
